stopwatch_ctrl: RTL

Control FSM for the stopwatch mode of the multi-mode clock. It converts the three user buttons into run-enable and clear commands for the `stop_watch` counter, and keeps a small lap buffer. It selects what the display path shows: live time, a frozen lap, or a recalled lap. It sits between the button synchronisers / mode selector and the `stop_watch` instance.

---
 rtl/clock_pkg.sv | 25 ++
 rtl/stopwatch_ctrl_if.sv | 38 +++
 rtl/edge_detect.sv | 22 ++
 rtl/stopwatch_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and mode codes for the multi-mode clock.
package clock_pkg;

  // Stopwatch control states. The encoding is visible on run_state.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    LAP_HOLD = 2'd2,
    PAUSE    = 2'd3
  } sw_state_t;

  // Mode-selector codes for cur_state.
  localparam logic [3:0] MODE_CLOCK     = 4'd0;
  localparam logic [3:0] MODE_ALARM     = 4'd1;
  localparam logic [3:0] MODE_STOPWATCH = 4'd2;
  localparam logic [3:0] MODE_SET       = 4'd3;

  // One time-of-day triple, 24 bits.
  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
  } time_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the mode selector / stop_watch counter and the control block.
interface stopwatch_ctrl_if #(
  parameter int LAPS = 4
) ();
  localparam int CW = $clog2(LAPS) + 1;

  logic [3:0]    cur_state;
  logic          btn_ss;
  logic          btn_lap;
  logic          btn_clr;
  logic [7:0]    live_second;
  logic [7:0]    live_minute;
  logic [7:0]    live_hour;
  logic          sw_start;
  logic          sw_clear;
  logic [7:0]    disp_second;
  logic [7:0]    disp_minute;
  logic [7:0]    disp_hour;
  logic [CW-1:0] lap_count;
  logic          lap_full;
  logic [1:0]    run_state;

  // Driving side: buttons, mode and the live counter.
  modport master (
    output cur_state, btn_ss, btn_lap, btn_clr,
    output live_second, live_minute, live_hour,
    input  sw_start, sw_clear, disp_second, disp_minute, disp_hour,
    input  lap_count, lap_full, run_state
  );

  // Control block side.
  modport slave (
    input  cur_state, btn_ss, btn_lap, btn_clr,
    input  live_second, live_minute, live_hour,
    output sw_start, sw_clear, disp_second, disp_minute, disp_hour,
    output lap_count, lap_full, run_state
  );
endinterface

// File: rtl/edge_detect.sv
// Registered rising-edge detector: a level sampled high at edge n after being
// low at edge n-1 produces a one-cycle pulse visible from edge n onward.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic prev;

  // History register and registered pulse; both clear on reset so a level
  // held through reset still yields one edge afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= level;
      rise <= level & ~prev;
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edges -> run/clear commands, lap buffer and
// display source selection (live, held lap, recalled lap).
module stopwatch_ctrl
  import clock_pkg::*;
#(
  parameter logic [3:0] MODE_SW = MODE_STOPWATCH,
  parameter int         LAPS    = 4
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave bus
);
  localparam int PW = $clog2(LAPS);
  localparam int CW = PW + 1;

  logic rise_ss, rise_lap, rise_clr;

  edge_detect u_ed_ss  (.clk(clk), .rst(rst), .level(bus.btn_ss),  .rise(rise_ss));
  edge_detect u_ed_lap (.clk(clk), .rst(rst), .level(bus.btn_lap), .rise(rise_lap));
  edge_detect u_ed_clr (.clk(clk), .rst(rst), .level(bus.btn_clr), .rise(rise_clr));

  // Mode gating and clr > ss > lap priority; a lower edge is dropped even
  // when the winning edge has no effect in the current state.
  logic in_mode, act_clr, act_ss, act_lap;
  assign in_mode = (bus.cur_state == MODE_SW);
  assign act_clr = in_mode & rise_clr;
  assign act_ss  = in_mode & rise_ss  & ~rise_clr;
  assign act_lap = in_mode & rise_lap & ~rise_ss & ~rise_clr;

  sw_state_t     state_q, state_d;
  time_t         lap_mem [LAPS];
  time_t         live, hold_q, disp_q, disp_d;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] lap_cnt;
  logic          full, recall_q, clr_q, start;
  logic          do_write, do_recall, do_clear, enter_pause, leave_pause;

  assign live = {bus.live_hour, bus.live_minute, bus.live_second};
  assign full = (lap_cnt == CW'(LAPS));

  assign do_write    = (state_q == RUN)   && act_lap && !full;
  assign do_recall   = (state_q == PAUSE) && act_lap && (lap_cnt != '0);
  assign do_clear    = (state_q == PAUSE) && act_clr;
  assign enter_pause = (state_d == PAUSE) && (state_q != PAUSE);
  assign leave_pause = (state_q == PAUSE) && act_ss;

  // Recall pointer walks modulo the number of stored laps.
  assign rd_next = ((CW'(rd_ptr) + CW'(1)) == lap_cnt) ? '0 : rd_ptr + PW'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (act_ss) state_d = RUN;
      RUN:      if (act_ss) state_d = PAUSE;
                else if (act_lap && !full) state_d = LAP_HOLD;
      LAP_HOLD: if (act_ss) state_d = PAUSE;
                else if (act_lap) state_d = RUN;
      PAUSE:    if (act_clr) state_d = IDLE;
                else if (act_ss) state_d = RUN;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs: run enable from state, and the next display source. A held lap
  // or an active recall keeps its value; everything else shows live time.
  always_comb begin
    start  = (state_q == RUN) || (state_q == LAP_HOLD);
    disp_d = live;
    if (do_recall)
      disp_d = lap_mem[rd_ptr];
    else if (state_q == LAP_HOLD && state_d == LAP_HOLD)
      disp_d = hold_q;
    else if (state_q == PAUSE && state_d == PAUSE && recall_q)
      disp_d = disp_q;
  end

  // Lap buffer, pointers, count and recall flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAPS; i++) lap_mem[i] <= '0;
      hold_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lap_cnt  <= '0;
      recall_q <= 1'b0;
    end else begin
      if (do_write) begin
        lap_mem[wr_ptr] <= live;
        hold_q          <= live;
        wr_ptr          <= wr_ptr + PW'(1);
        lap_cnt         <= lap_cnt + CW'(1);
      end
      if (do_clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        lap_cnt  <= '0;
        recall_q <= 1'b0;
      end else if (enter_pause) begin
        rd_ptr <= '0;
      end else if (do_recall) begin
        rd_ptr   <= rd_next;
        recall_q <= 1'b1;
      end else if (leave_pause) begin
        recall_q <= 1'b0;
      end
    end
  end

  // Registered display mux and one-cycle clear pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      clr_q  <= 1'b0;
    end else begin
      disp_q <= disp_d;
      clr_q  <= do_clear;
    end
  end

  // stop_watch is held cleared for the whole of reset.
  assign bus.sw_clear    = rst | clr_q;
  assign bus.sw_start    = start;
  assign bus.disp_hour   = disp_q.hour;
  assign bus.disp_minute = disp_q.minute;
  assign bus.disp_second = disp_q.second;
  assign bus.lap_count   = lap_cnt;
  assign bus.lap_full    = full;
  assign bus.run_state   = state_q;
endmodule
